// File: rtl/uart_cmd_parser.sv
// Turns 8-byte 0xA5-framed UART read/write commands into a valid/ready command
// port. Parity, illegal-command, checksum, overrun and inter-byte timeout errors are reported.
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ      = 100000000,
    parameter int unsigned UART_RATE     = 1000000,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_parity_err_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_wr_o,
    output logic [23:0] cmd_addr_o,
    output logic [15:0] cmd_data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);
    // 64-bit arithmetic: the intermediate product overflows 32 bits with the default parameters
    localparam longint unsigned TO_LIMIT_L =
        (64'(TIMEOUT_BYTES) * 64'd11 * 64'(CLK_FREQ)) / 64'(UART_RATE);
    localparam int unsigned TO_LIMIT = 32'(TO_LIMIT_L);
    localparam int unsigned TO_W     = (TO_LIMIT > 2) ? $clog2(TO_LIMIT) : 1;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_FRAME   = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_D1, S_D0, S_CHK, S_HOLD
    } state_e;

    state_e state_q, state_d;

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            wr_buf_q, wr_buf_d;
    logic [23:0]     addr_buf_q, addr_buf_d;
    logic [15:0]     data_buf_q, data_buf_d;
    logic [7:0]      chk_q, chk_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_wr_q, cmd_wr_d;
    logic [23:0]     cmd_addr_q, cmd_addr_d;
    logic [15:0]     cmd_data_q, cmd_data_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic in_frame_c, timeout_c, hs_c, sof_c, cmd_legal_c, chk_ok_c, bad_byte_c;

    assign in_frame_c  = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign timeout_c   = in_frame_c && !rx_valid_i && (cnt_q == TO_W'(TO_LIMIT - 1));
    assign hs_c        = cmd_valid_q && cmd_ready_i;
    assign sof_c       = rx_valid_i && !rx_parity_err_i && (rx_data_i == 8'hA5);
    assign cmd_legal_c = (rx_data_i == 8'h01) || (rx_data_i == 8'h02);
    assign chk_ok_c    = (rx_data_i == chk_q);
    assign bad_byte_c  = rx_parity_err_i || ((state_q == S_CMD) && !cmd_legal_c);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (sof_c) state_d = S_CMD;
            S_CMD, S_A2, S_A1, S_A0, S_D1, S_D0: begin
                if (timeout_c) state_d = S_IDLE;
                else if (rx_valid_i) begin
                    if (bad_byte_c) state_d = S_IDLE;
                    else begin
                        unique case (state_q)
                            S_CMD:   state_d = S_A2;
                            S_A2:    state_d = S_A1;
                            S_A1:    state_d = S_A0;
                            S_A0:    state_d = S_D1;
                            S_D1:    state_d = S_D0;
                            default: state_d = S_CHK;
                        endcase
                    end
                end
            end
            S_CHK: begin
                if (timeout_c) state_d = S_IDLE;
                else if (rx_valid_i) state_d = (!rx_parity_err_i && chk_ok_c) ? S_HOLD : S_IDLE;
            end
            S_HOLD: if (hs_c) state_d = sof_c ? S_CMD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_d       = '0;
        wr_buf_d    = wr_buf_q;
        addr_buf_d  = addr_buf_q;
        data_buf_d  = data_buf_q;
        chk_d       = chk_q;
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        if (in_frame_c) begin
            if (!rx_valid_i) begin
                cnt_d = cnt_q + TO_W'(1);
                if (timeout_c) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end else if (bad_byte_c) begin
                err_d      = 1'b1;
                err_code_d = ERR_FRAME;
            end else begin
                chk_d = chk_q ^ rx_data_i;
                unique case (state_q)
                    S_CMD: begin
                        wr_buf_d = (rx_data_i == 8'h01);
                        chk_d    = rx_data_i;
                    end
                    S_A2: addr_buf_d[23:16] = rx_data_i;
                    S_A1: addr_buf_d[15:8]  = rx_data_i;
                    S_A0: addr_buf_d[7:0]   = rx_data_i;
                    S_D1: data_buf_d[15:8]  = rx_data_i;
                    S_D0: data_buf_d[7:0]   = rx_data_i;
                    default: begin
                        if (chk_ok_c) begin
                            cmd_valid_d = 1'b1;
                            cmd_wr_d    = wr_buf_q;
                            cmd_addr_d  = addr_buf_q;
                            cmd_data_d  = data_buf_q;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CHKSUM;
                        end
                    end
                endcase
            end
        end else if (state_q == S_HOLD) begin
            if (hs_c) cmd_valid_d = 1'b0;
            else if (rx_valid_i) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVERRUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            wr_buf_q    <= 1'b0;
            addr_buf_q  <= '0;
            data_buf_q  <= '0;
            chk_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wr_buf_q    <= wr_buf_d;
            addr_buf_q  <= addr_buf_d;
            data_buf_q  <= data_buf_d;
            chk_q       <= chk_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_wr_o    = cmd_wr_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_data_o  = cmd_data_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected commands and
// errors, and a negedge monitor checks them as the DUT presents them.
module tb_uart_cmd_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_parity_err_i = 1'b0;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b1;
    logic        cmd_wr_o;
    logic [23:0] cmd_addr_o;
    logic [15:0] cmd_data_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    uart_cmd_parser dut (
        .clk(clk), .rst(rst),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_parity_err_i(rx_parity_err_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_wr_o(cmd_wr_o),
        .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] data;
        logic        data_care;
    } cmd_t;
    typedef struct {
        logic [1:0] code;
        int         at;    // expected edge count, -1 = any
    } err_t;

    cmd_t exp_cmd[$];
    err_t exp_err[$];
    int n_cmp = 0;
    int n_fail = 0;
    int last_edge = 0;

    localparam int unsigned TO_CYC = 4400;
    localparam logic [63:0] FR_WR   = 64'hA5_01_00_12_34_BE_EF_76;
    localparam logic [63:0] FR_RD   = 64'hA5_02_00_00_10_00_00_12;
    localparam logic [63:0] FR_BAD  = 64'hA5_01_00_12_34_BE_EF_77;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par);
        rx_data_i       = b;
        rx_parity_err_i = par;
        rx_valid_i      = 1'b1;
        last_edge       = cyc + 1;
        tick(1);
        rx_valid_i      = 1'b0;
        rx_parity_err_i = 1'b0;
    endtask

    // Sends frame bytes first..last, byte 0 being the most significant
    task automatic send_range(input logic [63:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(f[(7 - i) * 8 +: 8], 1'b0);
    endtask

    task automatic push_cmd(input logic wr, input logic [23:0] a, input logic [15:0] d, input logic dc);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d; c.data_care = dc;
        exp_cmd.push_back(c);
    endtask

    task automatic push_err(input logic [1:0] code, input int at);
        err_t e;
        e.code = code; e.at = at;
        exp_err.push_back(e);
    endtask

    // Monitor: handshakes, error pulses and stability of held commands
    logic        held_v = 1'b0;
    logic [40:0] held;
    always @(negedge clk) begin
        if (rst) held_v = 1'b0;
        else begin
            if (cmd_valid_o && held_v)
                check("hold_stable", {cmd_wr_o, cmd_addr_o, cmd_data_o}, held);
            if (cmd_valid_o && cmd_ready_i) begin
                if (exp_cmd.size() == 0) check("unexpected_cmd", {cmd_wr_o, cmd_addr_o, cmd_data_o}, '0);
                else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    check("cmd_wr", cmd_wr_o, c.wr);
                    check("cmd_addr", cmd_addr_o, c.addr);
                    if (c.data_care) check("cmd_data", cmd_data_o, c.data);
                end
            end
            if (err_o) begin
                if (exp_err.size() == 0) check("unexpected_err", {err_code_o, 1'b1}, '0);
                else begin
                    err_t e;
                    e = exp_err.pop_front();
                    check("err_code", err_code_o, e.code);
                    if (e.at >= 0) check("err_cycle", cyc, e.at);
                end
            end
            held_v = cmd_valid_o && !cmd_ready_i;
            held   = {cmd_wr_o, cmd_addr_o, cmd_data_o};
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        check("rst_outputs", {cmd_valid_o, cmd_wr_o, cmd_addr_o, cmd_data_o, err_o, err_code_o}, '0);

        // Write frame with ready high
        push_cmd(1'b1, 24'h001234, 16'hBEEF, 1'b1);
        send_range(FR_WR, 0, 7);
        check("wr_valid_next_cycle", cmd_valid_o, 1'b1);
        tick(1);
        check("wr_valid_one_cycle", cmd_valid_o, 1'b0);
        tick(3);

        // Read frame held 50 cycles with an overrun byte injected
        cmd_ready_i = 1'b0;
        push_cmd(1'b0, 24'h000010, 16'h0000, 1'b0);
        send_range(FR_RD, 0, 7);
        check("rd_valid", cmd_valid_o, 1'b1);
        tick(20);
        push_err(2'b00, cyc + 1);
        send_byte(8'h55, 1'b0);
        tick(29);
        check("rd_still_valid", cmd_valid_o, 1'b1);
        check("overrun_code_held", err_code_o, 2'b00);
        cmd_ready_i = 1'b1;
        tick(1);
        check("rd_valid_dropped", cmd_valid_o, 1'b0);
        tick(2);

        // Bad checksum, then a good frame
        send_range(FR_BAD, 0, 6);
        push_err(2'b10, cyc + 1);
        send_byte(8'h77, 1'b0);
        check("chk_no_valid", cmd_valid_o, 1'b0);
        tick(5);
        check("chk_code_held", err_code_o, 2'b10);
        push_cmd(1'b1, 24'h001234, 16'hBEEF, 1'b1);
        send_range(FR_WR, 0, 7);
        tick(3);

        // Illegal CMD, then a leading junk byte before a read
        send_byte(8'hA5, 1'b0);
        push_err(2'b01, cyc + 1);
        send_byte(8'h03, 1'b0);
        tick(2);
        send_byte(8'h11, 1'b0);
        push_cmd(1'b0, 24'h000010, 16'h0000, 1'b0);
        send_range(FR_RD, 0, 7);
        tick(3);

        // Parity error mid-frame, then a junk byte with parity error in IDLE
        send_range(FR_WR, 0, 2);
        push_err(2'b01, cyc + 1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h3C, 1'b1);
        tick(3);

        // Timeout 4400 cycles after the last strobe
        send_range(FR_WR, 0, 2);
        push_err(2'b11, last_edge + int'(TO_CYC));
        tick(TO_CYC + 5);
        check("timeout_code", err_code_o, 2'b11);

        // Byte arriving in the expiry cycle wins; frame completes
        send_range(FR_WR, 0, 2);
        tick(TO_CYC - 1);
        push_cmd(1'b1, 24'h001234, 16'hBEEF, 1'b1);
        send_range(FR_WR, 3, 7);
        tick(3);

        // Reset after byte 5 discards the partial frame
        send_range(FR_WR, 0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_outputs", {cmd_valid_o, cmd_wr_o, cmd_addr_o, cmd_data_o, err_o, err_code_o}, '0);
        send_range(FR_WR, 5, 7);
        tick(3);
        check("midrst_no_cmd", cmd_valid_o, 1'b0);
        push_cmd(1'b1, 24'h001234, 16'hBEEF, 1'b1);
        send_range(FR_WR, 0, 7);
        tick(10);

        check("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        check("err_queue_empty", 64'(exp_err.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_RATE, default 1000000, UART baud rate in bit/s.
REQ-003 SHALL have parameter TIMEOUT_BYTES, default 4, inter-byte timeout measured in UART character times.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx_data_i  input  8  received byte from the upstream UART receiver.
REQ-007 SHALL have port rx_valid_i  input  1  one-cycle strobe qualifying rx_data_i.
REQ-008 SHALL have port rx_parity_err_i  input  1  parity error flag, sampled with rx_valid_i.
REQ-009 SHALL have port cmd_valid_o  output  1  decoded command available.
REQ-010 SHALL have port cmd_ready_i  input  1  downstream (memory test controller) accepts the command.
REQ-011 SHALL have port cmd_wr_o  output  1  1 = write, 0 = read.
REQ-012 SHALL have port cmd_addr_o  output  24  command address.
REQ-013 SHALL have port cmd_data_o  output  16  write data; don't-care for reads.
REQ-014 SHALL have port err_o  output  1  one-cycle error pulse.
REQ-015 SHALL have port err_code_o  output  2  cause of the last error, held until the next error: 01 parity/illegal cmd, 10 checksum, 11 timeout, 00 overrun.

Function
REQ-016 SHALL parse fixed 8-byte frames: 0xA5, CMD, ADDR[23:16], ADDR[15:8], ADDR[7:0], DATA[15:8], DATA[7:0], CHK.
REQ-017 SHALL compute CHK as the XOR of bytes 2..7 (CMD through DATA[7:0]).
REQ-018 SHALL decode CMD 0x01 as write and CMD 0x02 as read; every other value is illegal.
REQ-019 SHALL implement states IDLE, CMD, A2, A1, A0, D1, D0, CHK and HOLD; each accepted byte advances one state.
REQ-020 SHALL, in IDLE, discard every byte other than 0xA5 silently (no err_o), including bytes with parity errors.
REQ-021 SHALL, in states CMD through CHK, abort to IDLE with err_o=1 and err_code_o=01 on a byte with rx_parity_err_i=1, or on an illegal CMD byte.
REQ-022 SHALL, on a CHK mismatch, go to IDLE with err_o=1 and err_code_o=10; on a match, register the fields, set cmd_valid_o=1 the cycle after the CHK byte strobe, and enter HOLD.
REQ-023 SHALL hold cmd_valid_o, cmd_wr_o, cmd_addr_o and cmd_data_o stable in HOLD until a cycle with cmd_valid_o=1 and cmd_ready_i=1; cmd_valid_o SHALL be 0 the next cycle.
REQ-024 SHALL, in HOLD without a handshake, drop any rx_valid_i byte and pulse err_o with err_code_o=00.
REQ-025 SHALL, when the handshake and rx_valid_i coincide in HOLD, complete the transfer and process the byte as if the parser were in IDLE.
REQ-026 SHALL run a timeout counter in states CMD through CHK, reloaded on every rx_valid_i.
REQ-027 SHALL set the timeout limit to TIMEOUT_BYTES*11*CLK_FREQ/UART_RATE cycles (4400 with defaults), computed at elaboration, with the counter width derived from this value.
REQ-028 SHALL, on timeout expiry, go to IDLE with err_o=1 and err_code_o=11; if rx_valid_i arrives in the expiry cycle, the byte wins and no timeout occurs.
REQ-029 SHALL keep the timeout counter idle in IDLE and HOLD.
REQ-030 SHALL make err_o high for exactly one cycle per error event.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter IDLE and clear cmd_valid_o, cmd_wr_o, cmd_addr_o, cmd_data_o, err_o, err_code_o and the timeout counter to 0.
REQ-032 SHALL, on reset mid-frame or in HOLD, discard the partial frame or pending command; no err_o SHALL be generated.
REQ-033 SHALL ignore rx_valid_i while rst=1.

Verification
REQ-034 Bytes A5 01 00 12 34 BE EF 76 with cmd_ready_i=1 -> one cmd_valid_o cycle; wr=1, addr=0x001234, data=0xBEEF; err_o never asserted.
REQ-035 Bytes A5 02 00 00 10 00 00 12 with cmd_ready_i=0 for 50 cycles, then 1 -> read with addr=0x000010 held stable for 50 cycles; one byte injected in HOLD -> err_o pulse, err_code_o=00.
REQ-036 Frame from REQ-034 with CHK=0x77 -> no cmd_valid_o; err_o pulse, err_code_o=10; next valid frame is accepted.
REQ-037 Bytes A5 03 ... -> err_code_o=01 at the CMD byte; bytes 11 A5 02 00 00 10 00 00 12 -> leading 0x11 ignored silently, read decoded.
REQ-038 A5 01 00, then silence -> err_code_o=11 exactly 4400 cycles after the last strobe; a byte arriving at cycle 4400 instead -> no error.
REQ-039 rst=1 asserted after byte 5 of the REQ-034 frame -> all outputs 0, no err_o; remaining bytes discarded until the next 0xA5.
